// File: rtl/perf_event_monitor_if.sv
// Control strobes, per-cycle event wires and the one-outstanding read port of perf_event_monitor.
interface perf_event_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
);
    localparam int IDX_W = $clog2(NUM_CH + 1);

    logic              start;
    logic              clear;
    logic              halt;
    logic [NUM_CH-1:0] event_in;
    logic              rd_req;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_valid;
    logic [CNT_W-1:0]  rd_data;
    logic              rd_busy;
    logic              running;
    logic              frozen;
    logic              timeout;
    logic [NUM_CH:0]   sat;

    modport master (
        output start, clear, halt, event_in, rd_req, rd_idx,
        input  rd_valid, rd_data, rd_busy, running, frozen, timeout, sat
    );

    modport slave (
        input  start, clear, halt, event_in, rd_req, rd_idx,
        output rd_valid, rd_data, rd_busy, running, frozen, timeout, sat
    );
endinterface

// File: rtl/perf_event_monitor.sv
// Saturating per-channel event counters plus a cycle counter, frozen on halt, with a cycle-budget
// watchdog and a two-stage registered read port.
//
//  state      | meaning
//  ST_IDLE    | counters hold, waiting for start
//  ST_RUN     | counting cycles and events, watchdog armed
//  ST_FROZEN  | halt seen, counts held until clear
//  ST_TIMEOUT | cycle budget exhausted, counts held until clear
module perf_event_monitor #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int MAX_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    perf_event_monitor_if.slave  bus
);
    localparam int               IDX_W   = $clog2(NUM_CH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_FROZEN  = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NUM_CH+1];
    logic [CNT_W-1:0] cnt_d [NUM_CH+1];
    logic [NUM_CH:0]  sat_q, sat_d;
    logic [NUM_CH:0]  inc;
    logic             count_en;
    logic             wd_hit;

    logic             rd_busy_q, rd_busy_d;
    logic             rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] rd_sel;
    logic             rd_accept;

    // Top slot of the counter array is the cycle counter; it counts every RUN cycle.
    assign inc    = {1'b1, bus.event_in};
    assign wd_hit = (MAX_CYC != 0) && (cnt_q[NUM_CH] == WD_LAST);

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.start) state_d = ST_RUN;
                ST_RUN: begin
                    if (bus.halt)   state_d = ST_FROZEN;
                    else if (wd_hit) state_d = ST_TIMEOUT;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // The cycle that leaves RUN (halt or watchdog) is still counted.
    always_comb begin
        count_en = (state_q == ST_RUN) && !bus.clear;
        sat_d    = sat_q;
        for (int i = 0; i <= NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bus.clear) begin
                cnt_d[i] = '0;
                sat_d[i] = 1'b0;
            end else if (count_en && inc[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    sat_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i <= NUM_CH; i++) begin
            if (rd_idx_q == IDX_W'(i)) rd_sel = cnt_q[i];
        end
    end

    // Busy lasts exactly one cycle: request accepted, then data captured on the next edge.
    always_comb begin
        rd_accept  = bus.rd_req && !rd_busy_q;
        rd_busy_d  = rd_accept;
        rd_valid_d = rd_busy_q;
        rd_idx_d   = rd_accept ? bus.rd_idx : rd_idx_q;
        rd_data_d  = rd_busy_q ? rd_sel : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '{default: '0};
            sat_q      <= '0;
            rd_busy_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            rd_busy_q  <= rd_busy_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.running  = (state_q == ST_RUN);
    assign bus.frozen   = (state_q == ST_FROZEN);
    assign bus.timeout  = (state_q == ST_TIMEOUT);
    assign bus.sat      = sat_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_perf_event_monitor.sv
// Bench for perf_event_monitor: a 32-bit instance with a 20-cycle watchdog and a 4-bit instance
// with the watchdog disabled; read responses are checked against a queue of expected counts.
module tb_perf_event_monitor;
    localparam int NUM_CH = 4;
    localparam int IDX_W  = $clog2(NUM_CH + 1);

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    perf_event_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(32)) ifa ();
    perf_event_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(4))  ifb ();

    perf_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(32), .MAX_CYC(20)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    perf_event_monitor #(.NUM_CH(NUM_CH), .CNT_W(4), .MAX_CYC(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] q_a [$];
    logic [31:0] q_b [$];

    typedef struct packed {
        logic [3:0] ev;
        int         nrun;
        int         e0;
        int         e1;
        int         e2;
        int         e3;
        int         ecyc;
    } seg_t;

    seg_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ifa.rd_valid === 1'b1) begin
            if (q_a.size() == 0) check("a_unexpected_rd_valid", 32'(ifa.rd_valid), 32'd0);
            else check("a_rd_data", ifa.rd_data, q_a.pop_front());
        end
        if (ifb.rd_valid === 1'b1) begin
            if (q_b.size() == 0) check("b_unexpected_rd_valid", 32'(ifb.rd_valid), 32'd0);
            else check("b_rd_data", 32'(ifb.rd_data), q_b.pop_front());
        end
    end

    task automatic rd_a(input int idx, input logic [31:0] exp, input string name);
        ifa.rd_req = 1'b1;
        ifa.rd_idx = IDX_W'(idx);
        q_a.push_back(exp);
        tick();
        ifa.rd_req = 1'b0;
        check({name, "_busy"}, 32'(ifa.rd_busy), 32'd1);
        tick();
        check({name, "_valid"}, 32'(ifa.rd_valid), 32'd1);
    endtask

    task automatic rd_b(input int idx, input logic [31:0] exp, input string name);
        ifb.rd_req = 1'b1;
        ifb.rd_idx = IDX_W'(idx);
        q_b.push_back(exp);
        tick();
        ifb.rd_req = 1'b0;
        check({name, "_busy"}, 32'(ifb.rd_busy), 32'd1);
        tick();
        check({name, "_valid"}, 32'(ifb.rd_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: bench did not reach its end, got stuck expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int ex [5];

        // ev, RUN cycles before halt, expected ch0..ch3, expected cycle count (halt cycle counted)
        tbl[0] = '{4'b0101, 10, 11,  0, 11,  0, 11};
        tbl[1] = '{4'b1111,  0,  1,  1,  1,  1,  1};
        tbl[2] = '{4'b1000,  5,  0,  0,  0,  6,  6};
        tbl[3] = '{4'b0110, 18,  0, 19, 19,  0, 19};
        tbl[4] = '{4'b0011, 19, 20, 20,  0,  0, 20};

        ifa.start = 1'b0; ifa.clear = 1'b0; ifa.halt = 1'b0; ifa.event_in = '0;
        ifa.rd_req = 1'b0; ifa.rd_idx = '0;
        ifb.start = 1'b0; ifb.clear = 1'b0; ifb.halt = 1'b0; ifb.event_in = '0;
        ifb.rd_req = 1'b0; ifb.rd_idx = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_running",  32'(ifa.running),  32'd0);
        check("rst_frozen",   32'(ifa.frozen),   32'd0);
        check("rst_timeout",  32'(ifa.timeout),  32'd0);
        check("rst_sat",      32'(ifa.sat),      32'd0);
        check("rst_rd_valid", 32'(ifa.rd_valid), 32'd0);
        check("rst_rd_busy",  32'(ifa.rd_busy),  32'd0);
        check("rst_rd_data",  ifa.rd_data,       32'd0);
        check("rst_b_sat",    32'(ifb.sat),      32'd0);

        // Table rows: run with a fixed event pattern, halt, keep events on, read everything back.
        for (int r = 0; r < 5; r++) begin
            ifa.clear = 1'b1; tick(); ifa.clear = 1'b0;
            ifa.start = 1'b1; ifa.event_in = tbl[r].ev; tick(); ifa.start = 1'b0;
            repeat (tbl[r].nrun) tick();
            ifa.halt = 1'b1; tick(); ifa.halt = 1'b0;
            check($sformatf("row%0d_frozen", r),  32'(ifa.frozen),  32'd1);
            check($sformatf("row%0d_running", r), 32'(ifa.running), 32'd0);
            check($sformatf("row%0d_timeout", r), 32'(ifa.timeout), 32'd0);
            repeat (3) tick();
            ifa.event_in = '0;
            ex = '{tbl[r].e0, tbl[r].e1, tbl[r].e2, tbl[r].e3, tbl[r].ecyc};
            for (int c = 0; c <= NUM_CH; c++) begin
                rd_a(c, 32'(ex[c]), $sformatf("row%0d_rd%0d", r, c));
            end
        end

        // Back-to-back request while busy is dropped; out-of-range indices read as zero.
        ifa.rd_req = 1'b1; ifa.rd_idx = IDX_W'(NUM_CH); q_a.push_back(32'd20);
        tick();
        ifa.rd_idx = '0;
        check("t4_busy_t1",  32'(ifa.rd_busy),  32'd1);
        check("t4_valid_t1", 32'(ifa.rd_valid), 32'd0);
        tick();
        ifa.rd_req = 1'b0;
        check("t4_valid_t2", 32'(ifa.rd_valid), 32'd1);
        check("t4_busy_t2",  32'(ifa.rd_busy),  32'd0);
        tick();
        check("t4_no_second_valid", 32'(ifa.rd_valid), 32'd0);
        rd_a(NUM_CH + 1, 32'd0, "t4_idx5");
        rd_a(7, 32'd0, "t4_idx7");

        // Watchdog: 20 RUN cycles without halt, with a read during RUN.
        ifa.clear = 1'b1; tick(); ifa.clear = 1'b0;
        ifa.start = 1'b1; tick(); ifa.start = 1'b0;
        repeat (5) tick();
        rd_a(NUM_CH, 32'd6, "t2_rd_in_run");
        repeat (12) tick();
        check("t2_running_c19", 32'(ifa.running), 32'd1);
        check("t2_timeout_c19", 32'(ifa.timeout), 32'd0);
        tick();
        check("t2_timeout", 32'(ifa.timeout), 32'd1);
        check("t2_running", 32'(ifa.running), 32'd0);
        rd_a(NUM_CH, 32'd20, "t2_cyc");
        ifa.start = 1'b1; tick(); ifa.start = 1'b0;
        check("t2_start_ignored", 32'(ifa.timeout), 32'd1);

        // clear beats halt; halt in IDLE is ignored; clear during a pending read.
        ifa.clear = 1'b1; tick(); ifa.clear = 1'b0;
        ifa.start = 1'b1; tick(); ifa.start = 1'b0;
        ifa.event_in = 4'b1111;
        repeat (3) tick();
        ifa.halt = 1'b1; ifa.clear = 1'b1; tick(); ifa.halt = 1'b0; ifa.clear = 1'b0;
        check("t5_running", 32'(ifa.running), 32'd0);
        check("t5_frozen",  32'(ifa.frozen),  32'd0);
        rd_a(0, 32'd0, "t5_ch0");
        rd_a(NUM_CH, 32'd0, "t5_cyc");
        ifa.event_in = 4'b0001;
        ifa.start = 1'b1; ifa.halt = 1'b1; tick(); ifa.start = 1'b0; ifa.halt = 1'b0;
        check("t5_run_after_start_halt", 32'(ifa.running), 32'd1);
        check("t5_not_frozen",           32'(ifa.frozen),  32'd0);
        repeat (4) tick();
        ifa.rd_req = 1'b1; ifa.rd_idx = '0; ifa.clear = 1'b1; q_a.push_back(32'd0);
        tick();
        ifa.rd_req = 1'b0; ifa.clear = 1'b0;
        check("t5_clr_rd_busy", 32'(ifa.rd_busy), 32'd1);
        tick();
        check("t5_clr_rd_valid", 32'(ifa.rd_valid), 32'd1);

        // Saturation on the 4-bit instance, watchdog disabled.
        ifb.clear = 1'b1; tick(); ifb.clear = 1'b0;
        ifb.start = 1'b1; tick(); ifb.start = 1'b0;
        ifb.event_in = 4'b0001;
        repeat (20) tick();
        check("t3_no_timeout", 32'(ifb.timeout), 32'd0);
        check("t3_running",    32'(ifb.running), 32'd1);
        ifb.halt = 1'b1; tick(); ifb.halt = 1'b0;
        ifb.event_in = '0;
        check("t3_sat", 32'(ifb.sat), 32'h11);
        rd_b(0, 32'd15, "t3_ch0");
        rd_b(NUM_CH, 32'd15, "t3_cyc");
        rd_b(1, 32'd0, "t3_ch1");
        ifb.clear = 1'b1; tick(); ifb.clear = 1'b0;
        check("t3_sat_cleared", 32'(ifb.sat), 32'd0);
        rd_b(0, 32'd0, "t3_ch0_cleared");

        // Reset in FROZEN with a read in flight: no response, everything back to reset values.
        ifa.start = 1'b1; tick(); ifa.start = 1'b0;
        repeat (2) tick();
        ifa.halt = 1'b1; tick(); ifa.halt = 1'b0;
        check("t6_frozen", 32'(ifa.frozen), 32'd1);
        rd_a(NUM_CH, 32'd3, "t6_cyc");
        ifa.rd_req = 1'b1; ifa.rd_idx = '0;
        tick();
        ifa.rd_req = 1'b0;
        check("t6_busy_before_rst", 32'(ifa.rd_busy), 32'd1);
        rst = 1'b1;
        tick();
        check("t6_rd_valid", 32'(ifa.rd_valid), 32'd0);
        check("t6_rd_busy",  32'(ifa.rd_busy),  32'd0);
        check("t6_rd_data",  ifa.rd_data,       32'd0);
        check("t6_frozen_0", 32'(ifa.frozen),   32'd0);
        check("t6_sat",      32'(ifa.sat),      32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_rd_valid_after", 32'(ifa.rd_valid), 32'd0);
        rd_a(0, 32'd0, "t6_ch0");
        rd_a(NUM_CH, 32'd0, "t6_cyc_zero");

        tick();
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
